// File: rtl/cvp14.sv
// cvp14: compact 16-bit multi-cycle core sharing one memory port
// between instruction fetch and data load/store.
module cvp14_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  ra0,
  input  logic [2:0]  ra1,
  input  logic [2:0]  ra2,
  output logic [15:0] rd0,
  output logic [15:0] rd1,
  output logic [15:0] rd2
);

  logic [15:0] scalar [0:7];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        scalar[i] <= '0;
      end
    end else if (we) begin
      scalar[waddr] <= wdata;
    end
  end

  assign rd0 = scalar[ra0];
  assign rd1 = scalar[ra1];
  assign rd2 = scalar[ra2];

endmodule

module cvp14 (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] DataIn,
  output logic [15:0] Addr,
  output logic        RD,
  output logic        WR,
  output logic [15:0] DataOut,
  output logic        V
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  localparam logic [3:0] OP_SADD = 4'h0;
  localparam logic [3:0] OP_SAND = 4'h1;
  localparam logic [3:0] OP_SOR  = 4'h2;
  localparam logic [3:0] OP_SLL  = 4'h3;
  localparam logic [3:0] OP_SLH  = 4'h4;
  localparam logic [3:0] OP_SLD  = 4'h5;
  localparam logic [3:0] OP_SST  = 4'h6;
  localparam logic [3:0] OP_BRZ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_e      state_q;
  state_e      state_d;
  logic [15:0] PC;
  logic [15:0] pc_d;
  logic [15:0] instruction;
  logic [15:0] instr_d;
  logic        v_d;

  logic [3:0]  op;
  logic [2:0]  rd_a;
  logic [2:0]  rs_a;
  logic [2:0]  rt_a;
  logic [5:0]  imm6;
  logic [7:0]  imm8;
  logic [8:0]  imm9;
  logic [11:0] imm12;

  logic [15:0] rd_val;
  logic [15:0] rs_val;
  logic [15:0] rt_val;
  logic [15:0] sum;
  logic        ovf;
  logic [15:0] ea;
  logic [15:0] br_tgt;

  logic        we;
  logic [15:0] wd;

  logic        is_fetch;
  logic        is_st;
  logic        is_ld;

  assign op    = instruction[15:12];
  assign rd_a  = instruction[11:9];
  assign rs_a  = instruction[8:6];
  assign rt_a  = instruction[5:3];
  assign imm6  = instruction[5:0];
  assign imm8  = instruction[7:0];
  assign imm9  = instruction[8:0];
  assign imm12 = instruction[11:0];

  cvp14_regs scalar (
    .clk   (Clk1),
    .rst_n (Reset),
    .we    (we),
    .waddr (rd_a),
    .wdata (wd),
    .ra0   (rd_a),
    .ra1   (rs_a),
    .ra2   (rt_a),
    .rd0   (rd_val),
    .rd1   (rs_val),
    .rd2   (rt_val)
  );

  assign sum    = rs_val + rt_val;
  assign ovf    = (rs_val[15] == rt_val[15]) &&
                  (sum[15] != rs_val[15]);
  assign ea     = rs_val + {{10{imm6[5]}}, imm6};
  assign br_tgt = PC + {{7{imm9[8]}}, imm9};

  always_comb begin
    state_d = state_q;
    pc_d    = PC;
    instr_d = instruction;
    v_d     = V;
    we      = 1'b0;
    wd      = '0;
    unique case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        instr_d = DataIn;
        pc_d    = PC + 16'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_SADD: begin
            we  = 1'b1;
            wd  = sum;
            v_d = ovf;
          end
          OP_SAND: begin
            we = 1'b1;
            wd = rs_val & rt_val;
          end
          OP_SOR: begin
            we = 1'b1;
            wd = rs_val | rt_val;
          end
          OP_SLL: begin
            we = 1'b1;
            wd = {8'h00, imm8};
          end
          OP_SLH: begin
            we = 1'b1;
            wd = {imm8, rd_val[7:0]};
          end
          OP_SLD: begin
            state_d = S_MEM;
          end
          OP_SST: begin
            state_d = S_FETCH;
          end
          OP_BRZ: begin
            if (rd_val == 16'h0000) begin
              pc_d = br_tgt;
            end
          end
          OP_JMP: begin
            pc_d = {4'h0, imm12};
          end
          OP_HALT: begin
            state_d = S_HALT;
          end
          default: begin
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM: begin
        we      = 1'b1;
        wd      = DataIn;
        state_d = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  always_ff @(posedge Clk1) begin
    if (!Reset) begin
      state_q     <= S_FETCH;
      PC          <= '0;
      instruction <= '0;
      V           <= 1'b0;
    end else begin
      state_q     <= state_d;
      PC          <= pc_d;
      instruction <= instr_d;
      V           <= v_d;
    end
  end

  assign is_fetch = (state_q == S_FETCH);
  assign is_st    = (state_q == S_EXEC) && (op == OP_SST);
  assign is_ld    = (state_q == S_EXEC) && (op == OP_SLD);

  // Port is quiet while held in reset so no stray access escapes.
  always_comb begin
    Addr    = PC;
    RD      = 1'b0;
    WR      = 1'b0;
    DataOut = '0;
    if (!Reset) begin
      Addr = '0;
    end else begin
      unique case (1'b1)
        is_fetch: begin
          RD = 1'b1;
        end
        is_st: begin
          Addr    = ea;
          WR      = 1'b1;
          DataOut = rd_val;
        end
        is_ld: begin
          Addr = ea;
          RD   = 1'b1;
        end
        default: begin
          Addr = PC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cvp14.sv
// Bench for cvp14: program vectors with a store scoreboard,
// plus reset, jump-loop and PC-wrap sequences.
module tb_cvp14;

  logic        Clk1 = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] DataIn;
  logic [15:0] Addr;
  logic        RD;
  logic        WR;
  logic [15:0] DataOut;
  logic        V;

  always #5 Clk1 = ~Clk1;

  cvp14 dut (
    .Clk1    (Clk1),
    .Reset   (Reset),
    .DataIn  (DataIn),
    .Addr    (Addr),
    .RD      (RD),
    .WR      (WR),
    .DataOut (DataOut),
    .V       (V)
  );

  logic [15:0] mem [0:65535];
  logic [15:0] img [0:63];
  logic [15:0] img_top = 16'h0000;
  logic [15:0] rdata = 16'h0000;

  // Program image is copied in while reset is held low.
  always @(posedge Clk1) begin
    if (!Reset) begin
      for (int a = 0; a < 64; a++) mem[a] <= img[a];
      mem[16'hFFFF] <= img_top;
    end else if (WR) begin
      mem[Addr] <= DataOut;
    end
    if (RD) rdata <= mem[Addr];
  end
  assign DataIn = rdata;

  int total = 0;
  int bad = 0;

  task automatic chk16(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } st_t;
  st_t sq[$];

  always @(negedge Clk1) begin
    if (Reset === 1'b1 && WR === 1'b1) begin
      chk1("rd_wr_excl", RD, 1'b0);
      if (sq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_wr: got addr %h data %h want none",
                 Addr, DataOut);
      end else begin
        st_t e;
        e = sq.pop_front();
        chk16("st_addr", Addr, e.a);
        chk16("st_data", DataOut, e.d);
      end
    end
  end

  function automatic logic [15:0] sll(input logic [2:0] r,
                                      input logic [7:0] i);
    return {4'h3, r, 1'b0, i};
  endfunction
  function automatic logic [15:0] slh(input logic [2:0] r,
                                      input logic [7:0] i);
    return {4'h4, r, 1'b0, i};
  endfunction
  function automatic logic [15:0] rrr(input logic [3:0] o,
    input logic [2:0] d, input logic [2:0] s, input logic [2:0] t);
    return {o, d, s, t, 3'b000};
  endfunction
  function automatic logic [15:0] mop(input logic [3:0] o,
    input logic [2:0] d, input logic [2:0] s, input logic [5:0] i);
    return {o, d, s, i};
  endfunction
  function automatic logic [15:0] brz(input logic [2:0] r,
                                      input logic [8:0] i);
    return {4'h7, r, i};
  endfunction
  function automatic logic [15:0] jmp(input logic [11:0] i);
    return {4'h8, i};
  endfunction

  localparam logic [15:0] H = 16'hF000;

  typedef struct packed {
    logic [7:0][15:0] prog;
    logic [2:0]       ridx;
    logic [15:0]      rexp;
    logic [15:0]      pcexp;
    logic             vexp;
    logic             has_st;
    logic [15:0]      st_a;
    logic [15:0]      st_d;
  } vec_t;
  vec_t vt [12];

  task automatic setv(input int i,
    input logic [15:0] w0, input logic [15:0] w1,
    input logic [15:0] w2, input logic [15:0] w3,
    input logic [15:0] w4, input logic [15:0] w5,
    input logic [15:0] w6, input logic [15:0] w7,
    input logic [2:0] r, input logic [15:0] re,
    input logic [15:0] pe, input logic ve, input logic hs,
    input logic [15:0] sa, input logic [15:0] sd);
    vt[i].prog = {w7, w6, w5, w4, w3, w2, w1, w0};
    vt[i].ridx = r;
    vt[i].rexp = re;
    vt[i].pcexp = pe;
    vt[i].vexp = ve;
    vt[i].has_st = hs;
    vt[i].st_a = sa;
    vt[i].st_d = sd;
  endtask

  task automatic clear_img();
    for (int a = 0; a < 64; a++) img[a] = 16'h0000;
    img_top = 16'h0000;
  endtask

  task automatic enter_reset();
    @(negedge Clk1);
    Reset = 1'b0;
    clear_img();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge Clk1);
    @(negedge Clk1);
    Reset = 1'b1;
  endtask

  int fetches;

  initial begin
    setv(0, sll(1, 8'h34), slh(1, 8'h12), H, H, H, H, H, H,
         3'd1, 16'h1234, 16'd3, 1'b0, 1'b0, 16'h0, 16'h0);
    setv(1, sll(2, 8'hFF), slh(2, 8'h7F), sll(3, 8'h01),
         rrr(4'h0, 4, 2, 3), H, H, H, H,
         3'd4, 16'h8000, 16'd5, 1'b1, 1'b0, 16'h0, 16'h0);
    setv(2, sll(2, 8'hFF), slh(2, 8'h7F), sll(3, 8'h01),
         rrr(4'h0, 4, 2, 3), sll(5, 8'h01), rrr(4'h0, 6, 5, 5), H, H,
         3'd6, 16'h0002, 16'd7, 1'b0, 1'b0, 16'h0, 16'h0);
    setv(3, sll(1, 8'hF0), sll(2, 8'h3C), rrr(4'h1, 3, 1, 2),
         H, H, H, H, H,
         3'd3, 16'h0030, 16'd4, 1'b0, 1'b0, 16'h0, 16'h0);
    setv(4, sll(1, 8'hF0), sll(2, 8'h3C), rrr(4'h2, 3, 1, 2),
         H, H, H, H, H,
         3'd3, 16'h00FC, 16'd4, 1'b0, 1'b0, 16'h0, 16'h0);
    setv(5, sll(1, 8'h11), brz(6, 9'd2), sll(1, 8'h22),
         sll(1, 8'h33), H, H, H, H,
         3'd1, 16'h0011, 16'd5, 1'b0, 1'b0, 16'h0, 16'h0);
    setv(6, sll(6, 8'h01), brz(6, 9'd2), sll(1, 8'h22), H,
         H, H, H, H,
         3'd1, 16'h0022, 16'd4, 1'b0, 1'b0, 16'h0, 16'h0);
    setv(7, jmp(12'h004), sll(1, 8'h99), H, H, sll(1, 8'h55),
         H, H, H,
         3'd1, 16'h0055, 16'd6, 1'b0, 1'b0, 16'h0, 16'h0);
    setv(8, sll(1, 8'h34), slh(1, 8'h12), sll(5, 8'h10),
         mop(4'h6, 1, 5, 6'h02), mop(4'h5, 7, 5, 6'h02), H, H, H,
         3'd7, 16'h1234, 16'd6, 1'b0, 1'b1, 16'h0012, 16'h1234);
    setv(9, sll(2, 8'hAB), sll(5, 8'h10), mop(4'h6, 2, 5, 6'h3E),
         mop(4'h5, 3, 5, 6'h3E), H, H, H, H,
         3'd3, 16'h00AB, 16'd5, 1'b0, 1'b1, 16'h000E, 16'h00AB);
    setv(10, sll(1, 8'hFF), slh(1, 8'hFF), sll(2, 8'h01),
         rrr(4'h0, 1, 1, 2), H, H, H, H,
         3'd1, 16'h0000, 16'd5, 1'b0, 1'b0, 16'h0, 16'h0);
    setv(11, slh(1, 8'h80), rrr(4'h0, 2, 1, 1), H, H, H, H, H, H,
         3'd2, 16'h0000, 16'd3, 1'b1, 1'b0, 16'h0, 16'h0);

    // Reset state and first fetch.
    clear_img();
    img[0] = 16'h3105;
    repeat (2) @(posedge Clk1);
    @(negedge Clk1);
    chk1("rst_rd", RD, 1'b0);
    chk1("rst_wr", WR, 1'b0);
    chk16("rst_addr", Addr, 16'h0000);
    chk16("rst_dout", DataOut, 16'h0000);
    chk16("rst_pc", dut.PC, 16'h0000);
    chk16("rst_instr", dut.instruction, 16'h0000);
    chk1("rst_v", V, 1'b0);
    Reset = 1'b1;
    #1;
    chk1("first_fetch_rd", RD, 1'b1);
    chk16("first_fetch_addr", Addr, 16'h0000);
    repeat (3) @(posedge Clk1);
    @(negedge Clk1);
    chk16("sll_s0", dut.scalar.scalar[0], 16'h0005);
    chk16("sll_pc", dut.PC, 16'h0001);
    chk16("second_fetch_addr", Addr, 16'h0001);

    for (int i = 0; i < 12; i++) begin
      enter_reset();
      for (int j = 0; j < 8; j++) img[j] = vt[i].prog[j];
      if (vt[i].has_st) sq.push_back({vt[i].st_a, vt[i].st_d});
      release_reset();
      repeat (60) @(posedge Clk1);
      @(negedge Clk1);
      chk16($sformatf("v%0d_reg", i),
            dut.scalar.scalar[vt[i].ridx], vt[i].rexp);
      chk16($sformatf("v%0d_pc", i), dut.PC, vt[i].pcexp);
      chk1($sformatf("v%0d_v", i), V, vt[i].vexp);
      chk1($sformatf("v%0d_halt_rd", i), RD, 1'b0);
      chk1($sformatf("v%0d_halt_wr", i), WR, 1'b0);
      chk16($sformatf("v%0d_st_pending", i), 16'(sq.size()), 16'd0);
      sq.delete();
    end

    // Reset asserted during the EXEC cycle of a store.
    enter_reset();
    img[0] = sll(1, 8'h77);
    img[1] = mop(4'h6, 1, 0, 6'h03);
    img[2] = H;
    release_reset();
    repeat (4) @(posedge Clk1);
    @(negedge Clk1);
    chk16("pre_rst_s1", dut.scalar.scalar[1], 16'h0077);
    @(posedge Clk1);
    #1;
    chk1("sst_exec_wr", WR, 1'b1);
    chk16("sst_exec_addr", Addr, 16'h0003);
    Reset = 1'b0;
    #1;
    chk1("mid_rst_wr", WR, 1'b0);
    chk1("mid_rst_rd", RD, 1'b0);
    chk16("mid_rst_addr", Addr, 16'h0000);
    chk16("mid_rst_dout", DataOut, 16'h0000);
    @(posedge Clk1);
    @(negedge Clk1);
    chk16("mid_rst_s1", dut.scalar.scalar[1], 16'h0000);
    chk16("mid_rst_pc", dut.PC, 16'h0000);
    chk16("mid_rst_instr", dut.instruction, 16'h0000);
    chk16("mid_rst_mem3", mem[3], 16'h0000);
    Reset = 1'b1;
    #1;
    chk1("restart_rd", RD, 1'b1);
    chk16("restart_addr", Addr, 16'h0000);

    // JMP 0 loops forever on address 0.
    enter_reset();
    img[0] = jmp(12'h000);
    release_reset();
    fetches = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (RD) begin
        fetches++;
        chk16("loop_fetch_addr", Addr, 16'h0000);
      end
      @(negedge Clk1);
    end
    chk16("loop_fetches", 16'(fetches), 16'd4);
    chk16("loop_pc", dut.PC, 16'h0000);

    // Backward branch from 0 lands on 0xFFFF; PC wraps to 0.
    enter_reset();
    img[0] = brz(0, 9'h1FE);
    img_top = H;
    release_reset();
    repeat (20) @(posedge Clk1);
    @(negedge Clk1);
    chk16("wrap_instr", dut.instruction, H);
    chk16("wrap_pc", dut.PC, 16'h0000);
    chk1("wrap_halt_rd", RD, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
